// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, data stage) in front of one shared memory port.
// Optional fetch starvation guard enabled with macro ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_sign,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        arb_busy
);

    typedef enum logic { IDLE, WAIT_RD } state_t;
    typedef enum logic { OWN_IF, OWN_D } owner_t;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("STARVE_LIMIT must be in 1..15");
    end

    state_t state_q, state_d;
    owner_t owner_q, owner_d;
    logic   can_issue, sel_d, sel_if, rsp_valid;
    logic   fetch_first;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_q, starve_cnt_d;

    // Counts data grants that overtook a waiting fetch; any fetch grant or idle fetch clears it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt)
            starve_cnt_d = 4'd0;
        else if (d_gnt && starve_cnt_q != LIMIT)
            starve_cnt_d = starve_cnt_q + 4'd1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) starve_cnt_q <= 4'd0;
        else       starve_cnt_q <= starve_cnt_d;
    end

    assign fetch_first = (starve_cnt_q == LIMIT);
`else
    assign fetch_first = 1'b0;
`endif

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        can_issue = !RESET && ((state_q == IDLE) || mem_rvalid);
        sel_d     = can_issue && d_req && !(fetch_first && if_req);
        sel_if    = can_issue && if_req && !sel_d;

        mem_req   = sel_d || sel_if;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_size  = 2'b00;
        mem_sign  = 1'b0;
        if (sel_d) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_size  = d_size;
            mem_sign  = d_sign;
        end else if (sel_if) begin
            mem_addr  = if_addr;
            mem_size  = 2'b10;
        end

        d_gnt  = sel_d && mem_ready;
        if_gnt = sel_if && mem_ready;

        // Responses are only meaningful while a read is outstanding; IDLE drops stray ones.
        rsp_valid = !RESET && (state_q == WAIT_RD) && mem_rvalid;
        if_rvalid = rsp_valid && (owner_q == OWN_IF);
        d_rvalid  = rsp_valid && (owner_q == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : 32'd0;
        d_rdata   = d_rvalid  ? mem_rdata : 32'd0;

        arb_busy  = !RESET && (state_q == WAIT_RD);

        state_d = state_q;
        owner_d = owner_q;
        if (rsp_valid)
            state_d = IDLE;
        if (d_gnt && !d_we) begin
            state_d = WAIT_RD;
            owner_d = OWN_D;
        end else if (if_gnt) begin
            state_d = WAIT_RD;
            owner_d = OWN_IF;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; read responses tracked in a scoreboard queue.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_sign, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic        mem_req, mem_we, mem_sign, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;
    logic        arb_busy;

    typedef struct packed {
        logic        to_d;
        logic [31:0] data;
    } rsp_t;
    rsp_t sb_q[$];
    rsp_t exp_rsp;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_sign(d_sign), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_sign(mem_sign),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .arb_busy(arb_busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_size = 0; d_sign = 0;
        mem_ready = 1; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic check_response();
        exp_rsp = sb_q.pop_front();
        check("rsp_d_rvalid",  {31'd0, d_rvalid},  {31'd0, exp_rsp.to_d});
        check("rsp_if_rvalid", {31'd0, if_rvalid}, {31'd0, !exp_rsp.to_d});
        check("rsp_d_rdata",   d_rdata,  exp_rsp.to_d ? exp_rsp.data : 32'd0);
        check("rsp_if_rdata",  if_rdata, exp_rsp.to_d ? 32'd0 : exp_rsp.data);
    endtask

    initial begin
        bit guard;
        logic exp_if;
`ifdef ARB_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        // Reset held with every input active: all outputs must stay low.
        RESET = 1;
        idle_inputs();
        if_req = 1; if_addr = 32'h44; d_req = 1; d_addr = 32'h88; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        #3;
        check("rst_mem_req",  {31'd0, mem_req},  32'd0);
        check("rst_gnts",     {30'd0, if_gnt, d_gnt}, 32'd0);
        check("rst_rvalids",  {30'd0, if_rvalid, d_rvalid}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_busy",     {31'd0, arb_busy}, 32'd0);
        step();
        RESET = 0;
        idle_inputs();
        settle();
        check("idle_mem_req",  {31'd0, mem_req}, 32'd0);
        check("idle_mem_addr", mem_addr, 32'd0);

        // Simultaneous reads: data wins.
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_addr = 32'h1000; d_size = 2'b01; d_sign = 1;
        settle();
        check("sim_d_gnt",    {31'd0, d_gnt},  32'd1);
        check("sim_if_gnt",   {31'd0, if_gnt}, 32'd0);
        check("sim_mem_addr", mem_addr, 32'h1000);
        check("sim_mem_size", {30'd0, mem_size}, 32'd1);
        check("sim_mem_sign", {31'd0, mem_sign}, 32'd1);
        sb_q.push_back('{to_d: 1'b1, data: 32'hDEAD_BEEF});
        step();
        idle_inputs();
        settle();
        check("wait_busy",    {31'd0, arb_busy}, 32'd1);
        check("wait_mem_req", {31'd0, mem_req},  32'd0);
        step();
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        settle();
        check_response();
        step();
        idle_inputs();
        settle();
        check("after_rsp_busy", {31'd0, arb_busy}, 32'd0);

        // Write completes at grant, then a fetch.
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h55;
        settle();
        check("wr_d_gnt",     {31'd0, d_gnt},  32'd1);
        check("wr_mem_we",    {31'd0, mem_we}, 32'd1);
        check("wr_mem_wdata", mem_wdata, 32'h55);
        step();
        idle_inputs();
        if_req = 1; if_addr = 32'h40;
        settle();
        check("wr_busy",     {31'd0, arb_busy}, 32'd0);
        check("if_gnt",      {31'd0, if_gnt}, 32'd1);
        check("if_mem_addr", mem_addr, 32'h40);
        check("if_mem_ctl",  {29'd0, mem_we, mem_size}, 32'h2);
        sb_q.push_back('{to_d: 1'b0, data: 32'h1234_5678});
        step();

        // Back-to-back: fetch response and a new data read in the same cycle.
        idle_inputs();
        d_req = 1; d_addr = 32'h2000; d_size = 2'b10;
        mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        settle();
        check_response();
        check("b2b_d_gnt",    {31'd0, d_gnt}, 32'd1);
        check("b2b_mem_addr", mem_addr, 32'h2000);
        sb_q.push_back('{to_d: 1'b1, data: 32'hCAFE_F00D});
        step();
        idle_inputs();
        settle();
        check("b2b_busy", {31'd0, arb_busy}, 32'd1);
        step();
        mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        settle();
        check_response();
        step();

        // Stray response in IDLE is dropped.
        idle_inputs();
        mem_rvalid = 1; mem_rdata = 32'h0BAD_0BAD;
        settle();
        check("stray_rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        check("stray_rdata",   if_rdata | d_rdata, 32'd0);
        step();

        // Memory stalls three cycles, then accepts.
        idle_inputs();
        mem_ready = 0; d_req = 1; d_we = 1; d_addr = 32'h300;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("stall_req_gnt", {30'd0, mem_req, d_gnt}, 32'h2);
            step();
        end
        mem_ready = 1;
        settle();
        check("stall_release_gnt", {31'd0, d_gnt}, 32'd1);
        step();

        // Withdrawn fetch request leaves no trace.
        idle_inputs();
        mem_ready = 0; if_req = 1; if_addr = 32'h500;
        settle();
        check("withdraw_gnt", {31'd0, if_gnt}, 32'd0);
        step();
        idle_inputs();
        settle();
        check("withdraw_busy", {31'd0, arb_busy}, 32'd0);

        // Reset during WAIT_RD abandons the read.
        if_req = 1; if_addr = 32'h600;
        settle();
        check("pre_rst_if_gnt", {31'd0, if_gnt}, 32'd1);
        sb_q.push_back('{to_d: 1'b0, data: 32'h6666_6666});
        step();
        idle_inputs();
        settle();
        check("pre_rst_busy", {31'd0, arb_busy}, 32'd1);
        RESET = 1;
        #2;
        check("mid_rst_busy", {31'd0, arb_busy}, 32'd0);
        RESET = 0;
        sb_q.delete();
        step();
        mem_rvalid = 1; mem_rdata = 32'h6666_6666;
        settle();
        check("post_rst_rvalids", {29'd0, if_rvalid, d_rvalid, arb_busy}, 32'd0);
        step();

        // Continuous contention with data writes.
        idle_inputs();
        if_req = 1; if_addr = 32'h700;
        d_req = 1; d_we = 1; d_addr = 32'h900;
        mem_rvalid = 1; mem_rdata = 32'h7777_7777;
        for (int c = 0; c < 10; c++) begin
            settle();
            exp_if = guard && (c % 5 == 4);
            check("starve_if_gnt",    {31'd0, if_gnt},    {31'd0, exp_if});
            check("starve_d_gnt",     {31'd0, d_gnt},     {31'd0, !exp_if});
            check("starve_if_rvalid", {31'd0, if_rvalid}, {31'd0, guard && c > 0 && (c % 5 == 0)});
            step();
        end

        check("sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
